// File: rtl/min_reduce_tracker_if.sv
// Bundles the candidate-group bus and the frame result bus of min_reduce_tracker.
//
// Signals:
//   MIN1_TriggerBoss            candidate group present this cycle
//   MIN1_Core1..8Index [IDX_W]  candidate index of each core
//   MIN1_Core1..8Value [VAL_W]  candidate SAD value of each core
//   FrameStart / FrameEnd       group is first / last of a frame (qualified by trigger)
//   BestIndex / BestValue       winner of the last completed frame
//   BestValid                   one-cycle frame-completion pulse
//   FrameGroups [16]            group count of the last completed frame
//   Busy                        some pipeline stage holds a valid group
//
// Modports: master drives the candidate groups and observes results,
// slave is the tracker itself.
interface min_reduce_tracker_if #(
    parameter int IDX_W = 16,
    parameter int VAL_W = 14
);
    logic             MIN1_TriggerBoss;
    logic [IDX_W-1:0] MIN1_Core1Index, MIN1_Core2Index, MIN1_Core3Index, MIN1_Core4Index;
    logic [IDX_W-1:0] MIN1_Core5Index, MIN1_Core6Index, MIN1_Core7Index, MIN1_Core8Index;
    logic [VAL_W-1:0] MIN1_Core1Value, MIN1_Core2Value, MIN1_Core3Value, MIN1_Core4Value;
    logic [VAL_W-1:0] MIN1_Core5Value, MIN1_Core6Value, MIN1_Core7Value, MIN1_Core8Value;
    logic             FrameStart;
    logic             FrameEnd;
    logic [IDX_W-1:0] BestIndex;
    logic [VAL_W-1:0] BestValue;
    logic             BestValid;
    logic [15:0]      FrameGroups;
    logic             Busy;

    modport master (
        output MIN1_TriggerBoss,
        output MIN1_Core1Index, MIN1_Core2Index, MIN1_Core3Index, MIN1_Core4Index,
        output MIN1_Core5Index, MIN1_Core6Index, MIN1_Core7Index, MIN1_Core8Index,
        output MIN1_Core1Value, MIN1_Core2Value, MIN1_Core3Value, MIN1_Core4Value,
        output MIN1_Core5Value, MIN1_Core6Value, MIN1_Core7Value, MIN1_Core8Value,
        output FrameStart, FrameEnd,
        input  BestIndex, BestValue, BestValid, FrameGroups, Busy
    );

    modport slave (
        input  MIN1_TriggerBoss,
        input  MIN1_Core1Index, MIN1_Core2Index, MIN1_Core3Index, MIN1_Core4Index,
        input  MIN1_Core5Index, MIN1_Core6Index, MIN1_Core7Index, MIN1_Core8Index,
        input  MIN1_Core1Value, MIN1_Core2Value, MIN1_Core3Value, MIN1_Core4Value,
        input  MIN1_Core5Value, MIN1_Core6Value, MIN1_Core7Value, MIN1_Core8Value,
        input  FrameStart, FrameEnd,
        output BestIndex, BestValue, BestValid, FrameGroups, Busy
    );
endinterface

// File: rtl/min_reduce_tracker.sv
// Finds the minimum SAD candidate of each 8-core group through a three-level
// registered comparison tree, then merges group minima across a frame and
// publishes the frame winner with a one-cycle BestValid pulse.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    min_reduce_tracker_if.slave: candidate group inputs, frame result outputs
//
// Timing: a group captured at edge E reaches the tree output after E+2, is
// merged into the accumulator at E+3 and a FrameEnd result appears together
// with BestValid at E+4.
module min_reduce_tracker #(
    parameter int IDX_W = 16,
    parameter int VAL_W = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    min_reduce_tracker_if.slave  bus
);

    logic [VAL_W-1:0] in_val [8];
    logic [IDX_W-1:0] in_idx [8];

    logic             s1_valid, s1_start, s1_end;
    logic [VAL_W-1:0] s1_val [4];
    logic [IDX_W-1:0] s1_idx [4];

    logic             s2_valid, s2_start, s2_end;
    logic [VAL_W-1:0] s2_val [2];
    logic [IDX_W-1:0] s2_idx [2];

    logic             s3_valid, s3_start, s3_end;
    logic [VAL_W-1:0] s3_val;
    logic [IDX_W-1:0] s3_idx;

    logic [VAL_W-1:0] acc_val;
    logic [IDX_W-1:0] acc_idx;
    logic [15:0]      acc_cnt;

    logic [VAL_W-1:0] merged_val;
    logic [IDX_W-1:0] merged_idx;
    logic [15:0]      merged_cnt;

    logic             done;
    logic [VAL_W-1:0] res_val;
    logic [IDX_W-1:0] res_idx;
    logic [15:0]      res_cnt;

    // Flatten the per-core bus signals so the tree can be written as loops.
    always_comb begin
        in_val[0] = bus.MIN1_Core1Value;  in_idx[0] = bus.MIN1_Core1Index;
        in_val[1] = bus.MIN1_Core2Value;  in_idx[1] = bus.MIN1_Core2Index;
        in_val[2] = bus.MIN1_Core3Value;  in_idx[2] = bus.MIN1_Core3Index;
        in_val[3] = bus.MIN1_Core4Value;  in_idx[3] = bus.MIN1_Core4Index;
        in_val[4] = bus.MIN1_Core5Value;  in_idx[4] = bus.MIN1_Core5Index;
        in_val[5] = bus.MIN1_Core6Value;  in_idx[5] = bus.MIN1_Core6Index;
        in_val[6] = bus.MIN1_Core7Value;  in_idx[6] = bus.MIN1_Core7Index;
        in_val[7] = bus.MIN1_Core8Value;  in_idx[7] = bus.MIN1_Core8Index;
    end

    // Control bits of the tree. Frame markers are gated by the trigger so a
    // marker on an idle cycle can never reach the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;  s1_start <= 1'b0;  s1_end <= 1'b0;
            s2_valid <= 1'b0;  s2_start <= 1'b0;  s2_end <= 1'b0;
            s3_valid <= 1'b0;  s3_start <= 1'b0;  s3_end <= 1'b0;
        end else begin
            s1_valid <= bus.MIN1_TriggerBoss;
            s1_start <= bus.MIN1_TriggerBoss & bus.FrameStart;
            s1_end   <= bus.MIN1_TriggerBoss & bus.FrameEnd;
            s2_valid <= s1_valid;  s2_start <= s1_start;  s2_end <= s1_end;
            s3_valid <= s2_valid;  s3_start <= s2_start;  s3_end <= s2_end;
        end
    end

    // Tree data path. Each node takes the higher-numbered side only when it
    // is strictly smaller, so the lowest-numbered core wins any tie.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (in_val[2*k+1] < in_val[2*k]) begin
                s1_val[k] <= in_val[2*k+1];
                s1_idx[k] <= in_idx[2*k+1];
            end else begin
                s1_val[k] <= in_val[2*k];
                s1_idx[k] <= in_idx[2*k];
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (s1_val[2*k+1] < s1_val[2*k]) begin
                s2_val[k] <= s1_val[2*k+1];
                s2_idx[k] <= s1_idx[2*k+1];
            end else begin
                s2_val[k] <= s1_val[2*k];
                s2_idx[k] <= s1_idx[2*k];
            end
        end
        if (s2_val[1] < s2_val[0]) begin
            s3_val <= s2_val[1];
            s3_idx <= s2_idx[1];
        end else begin
            s3_val <= s2_val[0];
            s3_idx <= s2_idx[0];
        end
    end

    // Merge the tree output into the running frame result. A FrameStart group
    // restarts the frame; otherwise only a strictly smaller value replaces the
    // held one so earlier groups win ties, and the count saturates.
    always_comb begin
        merged_val = acc_val;
        merged_idx = acc_idx;
        merged_cnt = acc_cnt;
        if (s3_start) begin
            merged_val = s3_val;
            merged_idx = s3_idx;
            merged_cnt = 16'd1;
        end else begin
            if (s3_val < acc_val) begin
                merged_val = s3_val;
                merged_idx = s3_idx;
            end
            if (acc_cnt != 16'hFFFF) begin
                merged_cnt = acc_cnt + 16'd1;
            end
        end
    end

    // Accumulator stage. On a FrameEnd group the merged result is captured
    // so the output stage can publish it together with the pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_val <= '1;
            acc_idx <= '1;
            acc_cnt <= 16'd0;
            done    <= 1'b0;
            res_val <= '1;
            res_idx <= '1;
            res_cnt <= 16'd0;
        end else begin
            done <= s3_valid & s3_end;
            if (s3_valid) begin
                acc_val <= merged_val;
                acc_idx <= merged_idx;
                acc_cnt <= merged_cnt;
                if (s3_end) begin
                    res_val <= merged_val;
                    res_idx <= merged_idx;
                    res_cnt <= merged_cnt;
                end
            end
        end
    end

    // Output stage: results change only on frame completion and hold between
    // frames, so they always line up with their BestValid pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.BestIndex   <= '1;
            bus.BestValue   <= '1;
            bus.FrameGroups <= 16'd0;
            bus.BestValid   <= 1'b0;
        end else begin
            bus.BestValid <= done;
            if (done) begin
                bus.BestIndex   <= res_idx;
                bus.BestValue   <= res_val;
                bus.FrameGroups <= res_cnt;
            end
        end
    end

    assign bus.Busy = s1_valid | s2_valid | s3_valid | done;

endmodule

// File: doc/min_reduce_tracker.md
MIN_REDUCE_TRACKER -- requirements
Module: min_reduce_tracker

Interface
REQ-001 The block SHALL have parameter IDX_W, default 16, meaning the candidate index width.
REQ-002 The block SHALL have parameter VAL_W, default 14, meaning the candidate SAD value width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; no other clock or reset SHALL exist.
REQ-004 Port clk  input  1  is the sole clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  is the reset: synchronous, active-low, sampled on the clk rising edge.
REQ-006 Port MIN1_TriggerBoss  input  1  SHALL mean a valid candidate group is present this cycle.
REQ-007 Ports MIN1_CoreNIndex  input  IDX_W, N=1..8, SHALL carry the candidate index of core N.
REQ-008 Ports MIN1_CoreNValue  input  VAL_W, N=1..8, SHALL carry the SAD value of core N.
REQ-009 Port FrameStart  input  1  SHALL mean the group qualified by MIN1_TriggerBoss is the first group of a frame.
REQ-010 Port FrameEnd  input  1  SHALL mean the group qualified by MIN1_TriggerBoss is the last group of a frame.
REQ-011 Port BestIndex  output  IDX_W  SHALL carry the winning index of the last completed frame.
REQ-012 Port BestValue  output  VAL_W  SHALL carry the winning SAD value of the last completed frame.
REQ-013 Port BestValid  output  1  SHALL be a one-cycle pulse marking frame completion.
REQ-014 Port FrameGroups  output  16  SHALL carry the group count of the last completed frame.
REQ-015 Port Busy  output  1  SHALL be high while any pipeline stage holds a valid group.

Function
REQ-016 FrameStart and FrameEnd SHALL be ignored in any cycle where MIN1_TriggerBoss is 0.
REQ-017 Stage 1 SHALL register four pairwise minima: (1,2), (3,4), (5,6), (7,8).
REQ-018 Stage 2 SHALL register two pairwise minima of the stage 1 results; stage 3 SHALL register the single group minimum.
REQ-019 Each tree node SHALL select the lower-numbered core on equal values, so core 1 wins a full tie.
REQ-020 The valid bit, FrameStart and FrameEnd SHALL travel with their group through all three stages.
REQ-021 Stage 4, the accumulator, SHALL load the group minimum when the stage 3 group carries FrameStart.
REQ-022 Otherwise, the accumulator SHALL replace its value only when the group value is strictly less; earlier groups win ties.
REQ-023 The group counter SHALL load 1 on a FrameStart group, increment on other valid groups, and saturate at 16'hFFFF.
REQ-024 When a stage 3 group carries FrameEnd, BestIndex, BestValue and FrameGroups SHALL update with the post-merge result and BestValid SHALL pulse on the next cycle edge.
REQ-025 The latency from the input group edge carrying FrameEnd to the BestValid edge SHALL be 4 cycles.
REQ-026 BestIndex, BestValue and FrameGroups SHALL hold until the next frame completes.
REQ-027 A group with both FrameStart and FrameEnd SHALL form a one-group frame: result = that group minimum, FrameGroups = 1.
REQ-028 Groups arriving before any FrameStart SHALL merge into the reset-initialised accumulator.
REQ-029 The block SHALL accept one group per cycle with no backpressure; back-to-back frames SHALL produce back-to-back BestValid pulses.
REQ-030 Value comparisons SHALL be unsigned at VAL_W bits; index SHALL pass through unchanged.

Reset
REQ-031 With rst_n = 0 at a clk edge, all stage valid bits SHALL clear, and BestValid = 0, Busy = 0.
REQ-032 Reset SHALL set BestIndex = all ones, BestValue = all ones, FrameGroups = 0, accumulator value = all ones, accumulator index = all ones, counter = 0.
REQ-033 Reset asserted mid-frame SHALL drop all in-flight groups; no BestValid SHALL result from them.

Verification
REQ-034 One group with FrameStart=FrameEnd=1, values 100..800 (core N = 100N), indices 0x10..0x80: BestValue=100, BestIndex=0x10, FrameGroups=1, pulse 4 cycles later.
REQ-035 All eight values = 50, indices 1..8: BestIndex=1.
REQ-036 Three-group frame with group minima 30, 20, 20 (indices 0xA, 0xB, 0xC): BestValue=20, BestIndex=0xB, FrameGroups=3.
REQ-037 Two back-to-back one-group frames with minima 7 then 9: BestValid high on consecutive cycles, showing 7 then 9.
REQ-038 rst_n low for one cycle, 2 cycles after a FrameEnd group: no BestValid, outputs at reset values, Busy = 0.
REQ-039 Group with MIN1_TriggerBoss = 0 and FrameEnd = 1, value 0: no effect on the accumulator, no BestValid.
